// File: rtl/async_fifo_pkg.sv
// ---------------------------------------------------------------------------
// async_fifo_pkg
// Shared helpers for the async FIFO write and read controllers.
//   ADDRSIZE_DEF / DSIZE_DEF : default address and data widths
//   bin2gray / gray2bin      : pointer code conversions
// The conversions work on a 32-bit container. Callers zero-extend narrower
// pointers on the way in and cast the result back down on the way out. Zero
// upper bits leave the low bits of either conversion unchanged, so one
// function body serves every pointer width up to 32 bits.
// ---------------------------------------------------------------------------
package async_fifo_pkg;

  localparam int ADDRSIZE_DEF = 4;
  localparam int DSIZE_DEF    = 8;
  localparam int GRAY_MAX_W   = 32;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter that owns its rotating priority pointer.
//   clk_i, rst_ni : clock and synchronous active-low reset
//   req_i         : per-requester request vector
//   enable_i      : when low, no grant is issued and the pointer holds
//   gnt_o         : one-hot grant (combinational)
//   gnt_idx_o     : index of the granted requester (0 when there is no grant)
// After a grant to index k, the search starts at k+1 on the next cycle.
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [NREQ-1:0] req_i,
  input  logic            enable_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDXW-1:0] gnt_idx_o
);

  logic [IDXW-1:0] rrPtr_q;
  logic [IDXW-1:0] rrPtr_d;
  logic            found;
  int              idx;

  // Scan the requesters starting at the priority pointer and wrapping
  // modulo NREQ. The first asserted request wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(rrPtr_q) + off) % NREQ;
      if (enable_i && !found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = IDXW'(idx);
      end
    end
  end

  // The pointer moves just past the winner. NREQ need not be a power of
  // two, so the wrap is explicit.
  always_comb begin
    rrPtr_d = rrPtr_q;
    if (found) begin
      rrPtr_d = (gnt_idx_o == IDXW'(NREQ - 1)) ? '0 : gnt_idx_o + IDXW'(1);
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rrPtr_q <= '0;
    end else begin
      rrPtr_q <= rrPtr_d;
    end
  end

endmodule

// File: rtl/wfifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// wfifo_write_arbiter
// Write-domain controller for the async FIFO. It shares the single RAM write
// port between NREQ requesters using round-robin order. It also owns the
// binary and Gray write pointers and the registered full flag.
//   wclk, wrst_n  : write clock, synchronous active-low reset
//   req, req_data : requests and packed data (slice i belongs to requester i)
//   gnt           : one-hot grant; the write happens on the same edge
//   wq2_rptr      : Gray read pointer, already synchronised into wclk
//   wen/waddr/wdata : RAM write port
//   wptr          : registered Gray write pointer, sent to the read side
//   wfull         : registered full flag
//   walmost_full  : registered almost-full flag (advisory only)
// Optional feature macro: WFA_ALMOST_FULL_EN. Defining it adds the
// walmost_full port and its logic.
// ---------------------------------------------------------------------------
module wfifo_write_arbiter
  import async_fifo_pkg::*;
#(
  parameter int ADDRSIZE     = ADDRSIZE_DEF,
  parameter int DSIZE        = DSIZE_DEF,
  parameter int NREQ         = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  input  logic [ADDRSIZE:0]     wq2_rptr,
  output logic                  wen,
  output logic [ADDRSIZE-1:0]   waddr,
  output logic [DSIZE-1:0]      wdata,
  output logic [ADDRSIZE:0]     wptr,
  output logic                  wfull
`ifdef WFA_ALMOST_FULL_EN
  ,
  output logic                  walmost_full
`endif
);

  localparam int PW   = ADDRSIZE + 1;
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [ADDRSIZE:0] wbin_q;
  logic [ADDRSIZE:0] wbin_d;
  logic [ADDRSIZE:0] wptr_q;
  logic [ADDRSIZE:0] wptr_d;
  logic              wfull_q;
  logic              wfull_d;
  logic [IDXW-1:0]   gntIdx;

  // Gating the grant with wrst_n drops any pending grant during reset.
  // Gating it with wfull makes overflow impossible.
  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr_arbiter (
    .clk_i    (wclk),
    .rst_ni   (wrst_n),
    .req_i    (req),
    .enable_i (wrst_n & ~wfull_q),
    .gnt_o    (gnt),
    .gnt_idx_o(gntIdx)
  );

  assign wen   = |gnt;
  assign waddr = wbin_q[ADDRSIZE-1:0];
  assign wdata = req_data[int'(gntIdx)*DSIZE +: DSIZE];
  assign wptr  = wptr_q;
  assign wfull = wfull_q;

  // The next pointer is computed here so that full can be decided on the
  // same edge as the write that fills the last slot. Full means the Gray
  // pointers match except in the top two bits, which are inverted.
  always_comb begin
    wbin_d  = wbin_q + {{ADDRSIZE{1'b0}}, wen};
    wptr_d  = PW'(bin2gray(GRAY_MAX_W'(wbin_d)));
    wfull_d = (wptr_d == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
  end

`ifdef WFA_ALMOST_FULL_EN
  logic [ADDRSIZE:0] wrbin;
  logic [ADDRSIZE:0] occNext;
  logic              walmostFull_q;
  logic              walmostFull_d;

  // The occupancy difference wraps naturally in PW bits, which handles
  // pointer wrap-around.
  always_comb begin
    wrbin         = PW'(gray2bin(GRAY_MAX_W'(wq2_rptr)));
    occNext       = wbin_d - wrbin;
    walmostFull_d = (int'(occNext) >= AFULL_THRESH);
  end

  assign walmost_full = walmostFull_q;
`endif

  // Pointer and flag registers.
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wbin_q        <= '0;
      wptr_q        <= '0;
      wfull_q       <= 1'b0;
`ifdef WFA_ALMOST_FULL_EN
      walmostFull_q <= 1'b0;
`endif
    end else begin
      wbin_q        <= wbin_d;
      wptr_q        <= wptr_d;
      wfull_q       <= wfull_d;
`ifdef WFA_ALMOST_FULL_EN
      walmostFull_q <= walmostFull_d;
`endif
    end
  end

endmodule

// File: doc/wfifo_write_arbiter.md
Name: wfifo_write_arbiter

Overview:
Write-side controller for the async FIFO, clocked in the write domain.
- Shares the single FIFO write port between NREQ requesters using round-robin arbitration.
- Owns the binary and Gray write pointers and the registered full flag.
- Consumes the read pointer after it has been synchronised into the write domain by the existing 2-flop synchroniser.
- Feeds wptr to the read-side synchroniser, and waddr/wdata/wen to the dual-port RAM.

Parameters:
ADDRSIZE, 4, FIFO address width; depth = 2**ADDRSIZE
DSIZE, 8, data width per requester
NREQ, 4, number of requesters (>=2)
AFULL_THRESH, 12, occupancy at or above which walmost_full asserts (only with WFA_ALMOST_FULL_EN)

Ports:
wclk  in  1  write-domain clock
wrst_n  in  1  synchronous active-low reset, sampled on posedge wclk
req  in  NREQ  per-requester write request; held with data until granted
req_data  in  NREQ*DSIZE  packed data; slice i belongs to requester i
gnt  out  NREQ  one-hot grant, combinational; write occurs at the same edge
wq2_rptr  in  ADDRSIZE+1  Gray read pointer, already synchronised into wclk
wen  out  1  RAM write enable (= |gnt)
waddr  out  ADDRSIZE  RAM write address (low bits of binary write pointer)
wdata  out  DSIZE  data of the granted requester
wptr  out  ADDRSIZE+1  registered Gray write pointer, to the read-side synchroniser
wfull  out  1  registered full flag
walmost_full  out  1  registered almost-full flag (only with WFA_ALMOST_FULL_EN)

Behaviour:
- Reset (wrst_n=0 at posedge wclk): wbin=0, wptr=0, wfull=0, walmost_full=0, rr_ptr=0. While wrst_n=0, gnt=0 and wen=0. A mid-operation reset discards any pending grant, and no write occurs on that edge.
- Arbitration (combinational):
  - If wfull=1 or req=0, then gnt=0.
  - Otherwise grant the first asserted req[i] searching i = rr_ptr, rr_ptr+1, ... modulo NREQ.
- Priority update: at a posedge with a grant to index k, rr_ptr <= (k+1) mod NREQ. rr_ptr is unchanged when there is no grant.
- Write: wen=|gnt; wdata=req_data slice of the granted index; waddr=wbin[ADDRSIZE-1:0].
- Handshake: a requester sees gnt[i]=1 while its req[i]=1. The transfer completes at that edge. The requester may drop req or present new data in the next cycle.
- Pointer update each posedge (not in reset):
  - wbin_next = wbin + wen, with natural wrap at 2**(ADDRSIZE+1).
  - wgray_next = (wbin_next>>1) ^ wbin_next.
  - wbin <= wbin_next; wptr <= wgray_next.
- Full: wfull <= (wgray_next == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
  - wfull is pessimistic: it clears only after the read pointer propagates through the synchroniser.
- Simultaneous events:
  - A write on the last free slot sets wfull on that same edge, so the next cycle has no grant.
  - A read advancing the synchronised wq2_rptr while full clears wfull on the next edge.
- No write ever occurs while wfull=1 (overflow impossible by construction).
- Wrap-around: the MSB of the pointer differentiates full from empty; the waddr low bits wrap naturally.

Optional Feature:
Macro WFA_ALMOST_FULL_EN.
- Defined:
  - Add port walmost_full.
  - wrbin = gray2bin(wq2_rptr); occ_next = (wbin_next - wrbin) mod 2**(ADDRSIZE+1).
  - walmost_full <= (occ_next >= AFULL_THRESH). Reset value 0.
  - walmost_full is advisory only and does not gate grants.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package async_fifo_pkg holds:
  - functions bin2gray and gray2bin, parameterised by width;
  - default constants ADDRSIZE_DEF=4 and DSIZE_DEF=8.
- One sub-module, rr_arbiter (NREQ parameter): req, enable, and rr_ptr state in; one-hot gnt out. It also owns the rr_ptr register and its update.
- Pointer/full logic stays in the top block.

Test Plan:
1. Reset then idle: hold wrst_n=0 for 3 cycles with req=4'b1111 -> gnt=0, wen=0, wptr=0, wfull=0. Release with req=0 -> outputs unchanged.
2. Round-robin: req=4'b1111 held, wq2_rptr=0 -> gnt sequence 0001,0010,0100,1000,0001. waddr 0,1,2,3,4; wdata matches the granted slice.
3. Fill to full: 16 grants with wq2_rptr=0 -> wfull rises on the edge of the 16th write, with wptr=5'b11000 (Gray of 16). gnt=0 thereafter and no further wen.
4. Drain while full: from test 3, set wq2_rptr=5'b00001 (Gray of 1) -> wfull=0 after the next edge. Exactly one more grant, then wfull=1 again.
5. Sparse fairness: req=4'b1010 from rr_ptr=0 -> gnt 0010, 1000, 0010. Then req=4'b0001 -> gnt=0001 immediately.
6. WFA_ALMOST_FULL_EN build with AFULL_THRESH=12: 11 writes -> walmost_full=0; 12th write -> walmost_full=1 on that edge. Advance wq2_rptr by 1 -> walmost_full=0 next edge. Mid-operation reset at 8 entries -> all pointers and flags return to 0.
